// File: rtl/cnn_pkg.sv
// cnn_pkg: types shared between the kernel bank and the convolution lanes.
//   COEF_W   - signed coefficient width
//   KSIZE    - coefficients per kernel (3x3)
//   kernel_t - one kernel, coefficient 0 in the LSBs
//   load_state_e / run_state_e - loader and run FSM encodings
package cnn_pkg;

  localparam int unsigned COEF_W = 8;
  localparam int unsigned KSIZE  = 9;

  typedef logic [KSIZE-1:0][COEF_W-1:0] kernel_t;

  typedef enum logic [1:0] {
    LIdle,
    LLoad,
    LFull
  } load_state_e;

  typedef enum logic {
    RIdle,
    RRun
  } run_state_e;

endpackage

// File: rtl/cnn_done_collector.sv
// cnn_done_collector: merges per-lane done pulses of one frame into a single pulse.
//   clk_i, nreset_i - clock, asynchronous active-low reset
//   clear_i         - clear the done mask (frame start)
//   en_i            - frame in progress; lane_done_i is ignored otherwise
//   lane_done_i     - per-lane done pulses
//   all_done_o      - combinational: every lane has reported, including this cycle
//   px_rdy_o        - registered one-cycle pulse following all_done_o
module cnn_done_collector #(
  parameter int unsigned N_LANES = 16
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [N_LANES-1:0] lane_done_i,
  output logic               all_done_o,
  output logic               px_rdy_o
);

  logic [N_LANES-1:0] mask_q, mask_d, merged;
  logic               px_rdy_q;

  always_comb begin
    merged     = mask_q | lane_done_i;
    all_done_o = en_i & (&merged);
    mask_d     = mask_q;
    if (clear_i) begin
      mask_d = '0;
    end else if (en_i) begin
      mask_d = merged;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      mask_q   <= '0;
      px_rdy_q <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      px_rdy_q <= all_done_o;
    end
  end

  assign px_rdy_o = px_rdy_q;

endmodule

// File: rtl/cnn_kernel_bank.sv
// cnn_kernel_bank: double-buffered kernel store and frame launch controller.
//   clk_i, nreset_i          - clock, asynchronous active-low reset
//   load_req_i               - start/restart loading a kernel set into the shadow bank
//   kernel_i, kernel_valid_i - kernel stream in, kernel_ready_o - shadow bank accepting
//   load_done_o              - pulse on bank swap, bank_valid_o - active bank complete
//   load_err_o               - sticky: kernel offered while not ready
//   kernels_o                - active bank, kernel i at slice i
//   start_cnn_i / start_o    - frame request / one-cycle lane start, busy_o - frame running
//   lane_done_i / px_rdy_o   - per-lane done / all-lanes-done pulse
module cnn_kernel_bank import cnn_pkg::*; #(
  parameter int unsigned N_KERNELS = 16,
  parameter int unsigned COEF_W    = cnn_pkg::COEF_W,
  parameter int unsigned KSIZE     = cnn_pkg::KSIZE
) (
  input  logic                              clk_i,
  input  logic                              nreset_i,
  input  logic                              load_req_i,
  input  logic [KSIZE*COEF_W-1:0]           kernel_i,
  input  logic                              kernel_valid_i,
  output logic                              kernel_ready_o,
  output logic                              load_done_o,
  output logic                              bank_valid_o,
  output logic                              load_err_o,
  output logic [N_KERNELS*KSIZE*COEF_W-1:0] kernels_o,
  input  logic                              start_cnn_i,
  output logic                              start_o,
  output logic                              busy_o,
  input  logic [N_KERNELS-1:0]              lane_done_i,
  output logic                              px_rdy_o
);

  localparam int unsigned CNT_W = $clog2(N_KERNELS);
  localparam int unsigned KW    = KSIZE * COEF_W;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_KERNELS - 1);

  load_state_e lstate_q, lstate_d;
  run_state_e  rstate_q, rstate_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             bank_valid_q, bank_valid_d;
  logic             load_err_q, load_err_d;
  logic             load_done_q;
  logic             start_q;
  logic             start_pend_q, start_pend_d;
  logic             wr_en, swap, start_accept, all_done, run_en;

  // bank_q[sel_q] is active, bank_q[!sel_q] is shadow; only the shadow is written.
  logic [1:0][N_KERNELS-1:0][KW-1:0] bank_q;

  // Loader FSM. load_req_i overrides any transfer or swap in the same cycle.
  always_comb begin
    lstate_d       = lstate_q;
    cnt_d          = cnt_q;
    wr_en          = 1'b0;
    swap           = 1'b0;
    kernel_ready_o = (lstate_q == LLoad);
    if (load_req_i) begin
      lstate_d = LLoad;
      cnt_d    = '0;
    end else begin
      unique case (lstate_q)
        LIdle: ;
        LLoad: begin
          if (kernel_valid_i) begin
            wr_en = 1'b1;
            if (cnt_q == LastIdx) begin
              lstate_d = LFull;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LFull: begin
          if (rstate_q == RIdle) begin
            swap     = 1'b1;
            lstate_d = LIdle;
          end
        end
        default: lstate_d = LIdle;
      endcase
    end
  end

  always_comb begin
    sel_d        = sel_q ^ swap;
    bank_valid_d = bank_valid_q | swap;
    if (load_req_i) begin
      load_err_d = 1'b0;
    end else begin
      load_err_d = load_err_q | (kernel_valid_i & ~kernel_ready_o);
    end
  end

  // Run FSM. A start arriving in the swap cycle is held over one cycle so the
  // lanes never see the bank change under a raised start_o.
  always_comb begin
    rstate_d     = rstate_q;
    start_pend_d = start_pend_q;
    start_accept = 1'b0;
    unique case (rstate_q)
      RIdle: begin
        if (swap) begin
          if (start_cnn_i) begin
            start_pend_d = 1'b1;
          end
        end else if ((start_cnn_i | start_pend_q) & bank_valid_q) begin
          start_accept = 1'b1;
          start_pend_d = 1'b0;
          rstate_d     = RRun;
        end
      end
      RRun: begin
        if (all_done) begin
          rstate_d = RIdle;
        end
      end
      default: rstate_d = RIdle;
    endcase
  end

  assign run_en = (rstate_q == RRun);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      lstate_q     <= LIdle;
      rstate_q     <= RIdle;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      bank_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
      load_done_q  <= 1'b0;
      start_q      <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      lstate_q     <= lstate_d;
      rstate_q     <= rstate_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      bank_valid_q <= bank_valid_d;
      load_err_q   <= load_err_d;
      load_done_q  <= swap;
      start_q      <= start_accept;
      start_pend_q <= start_pend_d;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      bank_q <= '0;
    end else if (wr_en) begin
      bank_q[!sel_q][cnt_q] <= kernel_i;
    end
  end

  cnn_done_collector #(
    .N_LANES(N_KERNELS)
  ) u_done_collector (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .clear_i    (start_accept),
    .en_i       (run_en),
    .lane_done_i(lane_done_i),
    .all_done_o (all_done),
    .px_rdy_o   (px_rdy_o)
  );

  assign kernels_o    = bank_q[sel_q];
  assign load_done_o  = load_done_q;
  assign bank_valid_o = bank_valid_q;
  assign load_err_o   = load_err_q;
  assign start_o      = start_q;
  assign busy_o       = run_en;

endmodule

// File: tb/tb_cnn_kernel_bank.sv
// Directed-sequence bench for cnn_kernel_bank with random kernel data and lane
// ordering; expected kernels come from the sets the bench itself pushed in.
module tb_cnn_kernel_bank;

  localparam int N  = 16;
  localparam int KW = 72;

  logic            clk = 1'b0;
  logic            nreset_i = 1'b1;
  logic            load_req_i = 1'b0;
  logic [KW-1:0]   kernel_i = '0;
  logic            kernel_valid_i = 1'b0;
  logic            kernel_ready_o, load_done_o, bank_valid_o, load_err_o;
  logic [N*KW-1:0] kernels_o;
  logic            start_cnn_i = 1'b0;
  logic            start_o, busy_o;
  logic [N-1:0]    lane_done_i = '0;
  logic            px_rdy_o;

  int errors = 0;
  int checks = 0;

  logic [KW-1:0] exp_active [N];
  logic [KW-1:0] set_buf    [N];

  always #5 clk = ~clk;

  cnn_kernel_bank #(
    .N_KERNELS(N),
    .COEF_W   (8),
    .KSIZE    (9)
  ) dut (
    .clk_i         (clk),
    .nreset_i      (nreset_i),
    .load_req_i    (load_req_i),
    .kernel_i      (kernel_i),
    .kernel_valid_i(kernel_valid_i),
    .kernel_ready_o(kernel_ready_o),
    .load_done_o   (load_done_o),
    .bank_valid_o  (bank_valid_o),
    .load_err_o    (load_err_o),
    .kernels_o     (kernels_o),
    .start_cnn_i   (start_cnn_i),
    .start_o       (start_o),
    .busy_o        (busy_o),
    .lane_done_i   (lane_done_i),
    .px_rdy_o      (px_rdy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_kernels(input string tag);
    for (int i = 0; i < N; i++) begin
      chkk($sformatf("%s[%0d]", tag, i), kernels_o[i*KW +: KW], exp_active[i]);
    end
  endtask

  // Streams set_buf[first..last-1] with occasional idle gaps.
  task automatic load_range(input int first, input int last);
    for (int i = first; i < last; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        kernel_valid_i = 1'b0;
        tick();
      end
      chk1($sformatf("ready_k%0d", i), kernel_ready_o, 1'b1);
      kernel_i       = set_buf[i];
      kernel_valid_i = 1'b1;
      tick();
      kernel_valid_i = 1'b0;
    end
  endtask

  task automatic load_req_pulse();
    load_req_i = 1'b1;
    tick();
    load_req_i = 1'b0;
  endtask

  task automatic rand_set();
    for (int i = 0; i < N; i++) set_buf[i] = KW'({$urandom(), $urandom(), $urandom()});
  endtask

  initial begin
    int order[15];
    int seq[$];
    byte b;

    for (int i = 0; i < N; i++) exp_active[i] = '0;

    // Reset values
    #1 nreset_i = 1'b0;
    #1;
    chk1("rst_ready", kernel_ready_o, 1'b0);
    chk1("rst_load_done", load_done_o, 1'b0);
    chk1("rst_bank_valid", bank_valid_o, 1'b0);
    chk1("rst_err", load_err_o, 1'b0);
    chk1("rst_start", start_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_px", px_rdy_o, 1'b0);
    chk_kernels("rst_kern");
    @(negedge clk) nreset_i = 1'b1;
    tick();

    // Start before any set is loaded is ignored
    start_cnn_i = 1'b1;
    tick();
    start_cnn_i = 1'b0;
    chk1("nostart_start", start_o, 1'b0);
    chk1("nostart_busy", busy_o, 1'b0);

    // First set: kernel i has every coefficient equal to i
    for (int i = 0; i < N; i++) begin
      b = 8'(i);
      set_buf[i] = {9{b}};
    end
    load_req_pulse();
    load_range(0, N);
    chk1("a_full_ready", kernel_ready_o, 1'b0);
    chk1("a_done_early", load_done_o, 1'b0);
    chk1("a_valid_early", bank_valid_o, 1'b0);
    tick();
    chk1("a_done", load_done_o, 1'b1);
    chk1("a_valid", bank_valid_o, 1'b1);
    for (int i = 0; i < N; i++) exp_active[i] = set_buf[i];
    chk_kernels("a_kern");
    chkk("a_slice5", kernels_o[5*KW +: KW], {9{8'h05}});
    tick();
    chk1("a_done_pulse", load_done_o, 1'b0);

    // Start a frame
    start_cnn_i = 1'b1;
    tick();
    start_cnn_i = 1'b0;
    chk1("f1_start", start_o, 1'b1);
    chk1("f1_busy", busy_o, 1'b1);
    tick();
    chk1("f1_start_pulse", start_o, 1'b0);
    chk1("f1_busy2", busy_o, 1'b1);

    // Second set loaded while running: swap must wait for the frame end
    for (int i = 0; i < N; i++) set_buf[i] = {9{8'hAA}};
    load_req_pulse();
    load_range(0, N);
    repeat (3) begin
      tick();
      chk1("b_wait_ready", kernel_ready_o, 1'b0);
      chk1("b_wait_done", load_done_o, 1'b0);
    end
    chk_kernels("b_wait_kern");
    start_cnn_i = 1'b1;
    tick();
    start_cnn_i = 1'b0;
    chk1("run_restart_ignored", start_o, 1'b0);

    // Lanes finish in random order, lane 3 twice, lane 15 last
    for (int i = 0; i < 15; i++) order[i] = i;
    for (int i = 14; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 15; i++) seq.push_back(order[i]);
    seq.insert(int'($urandom_range(15, 0)), 3);
    seq.push_back(15);
    for (int k = 0; k < seq.size(); k++) begin
      if ($urandom_range(2, 0) == 0) begin
        lane_done_i = '0;
        tick();
        chk1("lanes_gap_px", px_rdy_o, 1'b0);
      end
      lane_done_i = N'(1) << seq[k];
      tick();
      if (k != seq.size() - 1) begin
        chk1($sformatf("lanes_px_%0d", k), px_rdy_o, 1'b0);
        chk1($sformatf("lanes_busy_%0d", k), busy_o, 1'b1);
      end
    end
    lane_done_i = '0;
    chk1("f1_px", px_rdy_o, 1'b1);
    chk1("f1_idle", busy_o, 1'b0);
    chk1("b_no_swap_yet", load_done_o, 1'b0);
    chk_kernels("b_pre_swap_kern");
    tick();
    chk1("f1_px_pulse", px_rdy_o, 1'b0);
    chk1("b_done", load_done_o, 1'b1);
    for (int i = 0; i < N; i++) exp_active[i] = set_buf[i];
    chk_kernels("b_kern");
    tick();
    chk1("b_done_pulse", load_done_o, 1'b0);

    // lane_done_i while idle is ignored
    lane_done_i = '1;
    tick();
    lane_done_i = '0;
    chk1("idle_lanes_px", px_rdy_o, 1'b0);
    chk1("idle_lanes_busy", busy_o, 1'b0);
    tick();
    chk1("idle_lanes_px2", px_rdy_o, 1'b0);

    // Swap and start in the same cycle: swap first, start one cycle later
    rand_set();
    load_req_pulse();
    load_range(0, N);
    start_cnn_i = 1'b1;
    tick();
    chk1("c_done", load_done_o, 1'b1);
    chk1("c_start_deferred", start_o, 1'b0);
    for (int i = 0; i < N; i++) exp_active[i] = set_buf[i];
    chk_kernels("c_kern");
    tick();
    start_cnn_i = 1'b0;
    chk1("c_start", start_o, 1'b1);
    chk1("c_busy", busy_o, 1'b1);
    lane_done_i = '1;
    tick();
    lane_done_i = '0;
    chk1("c_px", px_rdy_o, 1'b1);
    chk1("c_idle", busy_o, 1'b0);
    tick();
    chk1("c_px_pulse", px_rdy_o, 1'b0);

    // Kernel offered while idle: sticky error, cleared by load_req_i
    kernel_i       = KW'({$urandom(), $urandom(), $urandom()});
    kernel_valid_i = 1'b1;
    tick();
    kernel_valid_i = 1'b0;
    chk1("err_set", load_err_o, 1'b1);
    tick();
    chk1("err_sticky", load_err_o, 1'b1);
    chk_kernels("err_kern");
    load_req_pulse();
    chk1("err_clear", load_err_o, 1'b0);

    // Restart after 7 kernels: a full 16 more are needed
    rand_set();
    load_range(0, 7);
    load_req_pulse();
    rand_set();
    load_range(0, N - 1);
    chk1("e_still_loading", kernel_ready_o, 1'b1);
    chk1("e_no_done", load_done_o, 1'b0);
    load_range(N - 1, N);
    chk1("e_full", kernel_ready_o, 1'b0);
    tick();
    chk1("e_done", load_done_o, 1'b1);
    for (int i = 0; i < N; i++) exp_active[i] = set_buf[i];
    chk_kernels("e_kern");

    // Reset in the middle of a frame and a load
    start_cnn_i = 1'b1;
    tick();
    start_cnn_i = 1'b0;
    chk1("r_busy", busy_o, 1'b1);
    rand_set();
    load_req_pulse();
    load_range(0, 5);
    #2 nreset_i = 1'b0;
    #1;
    for (int i = 0; i < N; i++) exp_active[i] = '0;
    chk1("r_busy0", busy_o, 1'b0);
    chk1("r_valid0", bank_valid_o, 1'b0);
    chk1("r_ready0", kernel_ready_o, 1'b0);
    chk1("r_start0", start_o, 1'b0);
    chk1("r_done0", load_done_o, 1'b0);
    chk1("r_px0", px_rdy_o, 1'b0);
    chk1("r_err0", load_err_o, 1'b0);
    chk_kernels("r_kern");
    @(negedge clk) nreset_i = 1'b1;
    tick();
    start_cnn_i = 1'b1;
    tick();
    start_cnn_i = 1'b0;
    chk1("r_nostart", start_o, 1'b0);
    chk1("r_idle_ready", kernel_ready_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_kernel_bank.md
Name: cnn_kernel_bank

Overview:
Parametrised, double-buffered kernel store and launch controller for the multi-lane convolution array. It loads N_KERNELS 3x3 kernels through a valid/ready stream into a shadow bank, then swaps the shadow bank into the active bank only while no convolution is running. The active bank drives all lanes. The block also gates the lane start and merges per-lane completion into one frame-done pulse, so kernel reload overlaps computation.

Parameters:
N_KERNELS, 16, number of kernels and conv lanes (2..64)
COEF_W, 8, signed coefficient width
KSIZE, 9, coefficients per kernel (3x3)
CNT_W, $clog2(N_KERNELS), load-counter width (derived, localparam)

Ports:
clk_i  in  1  clock, rising edge
nreset_i  in  1  asynchronous active-low reset
load_req_i  in  1  pulse: begin or restart loading a new kernel set into the shadow bank
kernel_i  in  KSIZE*COEF_W  one kernel, coefficient 0 in the LSBs
kernel_valid_i  in  1  kernel_i valid
kernel_ready_o  out  1  shadow bank accepting kernels
load_done_o  out  1  one-cycle pulse on bank swap
bank_valid_o  out  1  active bank holds a complete set
load_err_o  out  1  sticky: kernel_valid_i seen while kernel_ready_o=0
kernels_o  out  N_KERNELS*KSIZE*COEF_W  active bank, kernel i at slice i
start_cnn_i  in  1  request to start a frame
start_o  out  1  one-cycle start pulse to all lanes
busy_o  out  1  frame in progress
lane_done_i  in  N_KERNELS  per-lane done pulse
px_rdy_o  out  1  one-cycle pulse when every lane has reported done

Behaviour:
- Reset values: all outputs 0; both banks zeroed; counters 0; FSMs idle; bank_sel=0.
- Loader FSM states: L_IDLE, L_LOAD, L_FULL.
  - L_IDLE: on load_req_i, go to L_LOAD and set cnt=0.
  - L_LOAD: kernel_ready_o=1. Each cycle with kernel_valid_i=1 writes kernel_i to shadow[cnt] and increments cnt. The transfer at cnt==N_KERNELS-1 moves to L_FULL and sets cnt=0.
  - L_FULL: kernel_ready_o=0. When the run FSM is R_IDLE, perform the swap: flip bank_sel, set bank_valid_o=1, pulse load_done_o on the next cycle, go to L_IDLE.
  - A swap is never performed while in R_RUN; the loader waits in L_FULL.
- load_req_i while in L_LOAD or L_FULL discards the shadow contents: cnt=0, go to L_LOAD. load_req_i wins over a same-cycle kernel transfer or swap.
- The active bank is never written. kernels_o changes only on a swap edge.
- load_err_o: set when kernel_valid_i=1 and kernel_ready_o=0. Cleared only by load_req_i or reset. Offending data is dropped.
- Run FSM states: R_IDLE, R_RUN.
  - R_IDLE: when start_cnn_i=1 and bank_valid_o=1, register start_o=1 for exactly one cycle, clear the done mask, go to R_RUN.
  - start_cnn_i while bank_valid_o=0 is ignored.
  - If a swap and start_cnn_i occur in the same cycle, the swap takes effect and start is accepted on the following cycle. The new bank is therefore stable before start_o rises.
- R_RUN: busy_o=1. The done mask ORs in lane_done_i each cycle. When the mask, including the current cycle's lane_done_i, is all-ones: px_rdy_o=1 next cycle, return to R_IDLE.
  - Further start_cnn_i pulses in R_RUN are ignored.
  - lane_done_i in R_IDLE is ignored.
- Latency:
  - start_cnn_i to start_o: 1 cycle.
  - Last lane_done_i to px_rdy_o: 1 cycle.
  - Final kernel transfer to load_done_o: 2 cycles if run FSM idle.
- Reset mid-load or mid-frame returns everything to reset state. Banks are cleared.

Decomposition:
- Package cnn_pkg: COEF_W, KSIZE, the kernel_t packed type (KSIZE x COEF_W), and the loader and run FSM state enums. These are shared with conv lanes.
- One sub-module: cnn_done_collector, containing the N_KERNELS-wide done mask and the all-done pulse generation.
- Banks and both FSMs stay in the top.

Test Plan:
- Reset, then load 16 kernels with kernel i = all coefficients i -> load_done_o pulses once; bank_valid_o=1; kernels_o slice 5 = 9 x 8'h05.
- start_cnn_i before any load -> start_o stays 0. After load, start_cnn_i -> start_o high exactly 1 cycle, busy_o=1.
- Start frame, then fully load a second set (all 8'hAA) during R_RUN -> kernels_o unchanged until all 16 lane_done_i seen; px_rdy_o pulses; swap follows and load_done_o pulses.
- Lanes done in scattered cycles, lane 3 twice, lane 15 last -> px_rdy_o exactly once, 1 cycle after lane 15's pulse.
- kernel_valid_i in L_IDLE -> load_err_o=1 and banks unchanged; load_req_i clears it. load_req_i after 7 kernels -> cnt restarts, 16 more required.
- Deassert nreset_i mid-frame and mid-load -> all outputs 0 immediately; kernels_o=0; bank_valid_o=0.
